// File: rtl/ram_arbiter.sv
// Shares one blockram (sync write port, 1-cycle registered read port) between a
// cpu port (A) and a monitor port (B), one serialized transaction at a time.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [7:0]            a_wdata,
    output logic                  a_ack,
    output logic [7:0]            a_rdata,
    output logic                  a_grant,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [7:0]            b_wdata,
    output logic                  b_ack,
    output logic [7:0]            b_rdata,
    output logic                  b_grant,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [7:0]            ram_din,
    output logic                  ram_write,
    input  logic [7:0]            ram_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RADDR = 3'd2,
        RWAIT = 3'd3,
        RACK  = 3'd4
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [7:0] WAIT_SAT   = 8'hFF;

    state_t                state_r;
    state_t                state_s;
    logic                  win_b_r;
    logic                  win_b_s;
    logic                  last_b_r;
    logic                  last_b_s;
    logic [7:0]            wait_cnt_r;
    logic [7:0]            wait_cnt_s;
    logic                  a_block_r;
    logic                  b_block_r;
    logic                  a_elig_s;
    logic                  b_elig_s;
    logic                  force_b_s;
    logic                  pick_b_s;
    logic                  decide_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [7:0]            sel_wdata_s;
    logic                  ack_s;
    logic                  a_ack_r;
    logic                  b_ack_r;
    logic                  a_grant_r;
    logic                  b_grant_r;
    logic                  ram_write_r;
    logic [7:0]            a_rdata_r;
    logic [7:0]            b_rdata_r;
    logic [7:0]            ram_din_r;
    logic [ADDR_WIDTH-1:0] ram_waddr_r;
    logic [ADDR_WIDTH-1:0] ram_raddr_r;

    // Arbitration: eligibility, aging override and winner selection in IDLE.
    always_comb begin
        a_elig_s  = a_req && !a_block_r;
        b_elig_s  = b_req && !b_block_r;
        force_b_s = (FIXED_PRIO != 0) && (wait_cnt_r >= MAX_WAIT_C);
        pick_b_s  = 1'b0;
        if (a_elig_s && b_elig_s) begin
            if (FIXED_PRIO != 0) begin
                pick_b_s = force_b_s;
            end else begin
                pick_b_s = !last_b_r;
            end
        end else if (b_elig_s) begin
            pick_b_s = 1'b1;
        end else begin
            pick_b_s = 1'b0;
        end
        decide_s    = (state_r == IDLE) && (a_elig_s || b_elig_s);
        sel_we_s    = pick_b_s ? b_we    : a_we;
        sel_addr_s  = pick_b_s ? b_addr  : a_addr;
        sel_wdata_s = pick_b_s ? b_wdata : a_wdata;
    end

    // Next-state, winner/last-grant bookkeeping and the B aging counter.
    always_comb begin
        state_s  = state_r;
        win_b_s  = win_b_r;
        last_b_s = last_b_r;
        case (state_r)
            IDLE: begin
                if (decide_s) begin
                    state_s  = sel_we_s ? WRITE : RADDR;
                    win_b_s  = pick_b_s;
                    last_b_s = pick_b_s;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE:   state_s = IDLE;
            RADDR:   state_s = RWAIT;
            RWAIT:   state_s = RACK;
            RACK:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        ack_s = (state_s == WRITE) || (state_s == RACK);
        // Counter only ages while B is actually waiting.
        if ((FIXED_PRIO == 0) || !b_req || (decide_s && pick_b_s) || b_grant_r) begin
            wait_cnt_s = 8'd0;
        end else if (wait_cnt_r != WAIT_SAT) begin
            wait_cnt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_s = wait_cnt_r;
        end
    end

    // State, arbitration history and post-ack request masks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            win_b_r    <= 1'b0;
            last_b_r   <= 1'b1;
            wait_cnt_r <= 8'd0;
            a_block_r  <= 1'b0;
            b_block_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            win_b_r    <= win_b_s;
            last_b_r   <= last_b_s;
            wait_cnt_r <= wait_cnt_s;
            a_block_r  <= a_ack_r;
            b_block_r  <= b_ack_r;
        end
    end

    // Registered port and ram outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_ack_r     <= 1'b0;
            b_ack_r     <= 1'b0;
            a_grant_r   <= 1'b0;
            b_grant_r   <= 1'b0;
            ram_write_r <= 1'b0;
            ram_waddr_r <= {ADDR_WIDTH{1'b0}};
            ram_raddr_r <= {ADDR_WIDTH{1'b0}};
            ram_din_r   <= 8'd0;
        end else begin
            a_ack_r     <= ack_s && !win_b_s;
            b_ack_r     <= ack_s && win_b_s;
            a_grant_r   <= (state_s != IDLE) && !win_b_s;
            b_grant_r   <= (state_s != IDLE) && win_b_s;
            ram_write_r <= (state_s == WRITE);
            if (decide_s && sel_we_s) begin
                ram_waddr_r <= sel_addr_s;
                ram_din_r   <= sel_wdata_s;
            end
            if (decide_s && !sel_we_s) begin
                ram_raddr_r <= sel_addr_s;
            end
        end
    end

    // Read data capture at the end of RWAIT into the winner's holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata_r <= 8'd0;
            b_rdata_r <= 8'd0;
        end else if (state_r == RWAIT) begin
            if (win_b_r) begin
                b_rdata_r <= ram_dout;
            end else begin
                a_rdata_r <= ram_dout;
            end
        end
    end

    assign a_ack     = a_ack_r;
    assign b_ack     = b_ack_r;
    assign a_grant   = a_grant_r;
    assign b_grant   = b_grant_r;
    assign a_rdata   = a_rdata_r;
    assign b_rdata   = b_rdata_r;
    assign ram_write = ram_write_r;
    assign ram_waddr = ram_waddr_r;
    assign ram_raddr = ram_raddr_r;
    assign ram_din   = ram_din_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: one round-robin instance and one fixed-priority
// instance (MAX_WAIT=4), each in front of a behavioural blockram.
module tb_ram_arbiter;

    typedef struct {
        int         port;
        logic       we;
        logic [12:0] addr;
        logic [7:0] data;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        req   [2][2];
    logic        we    [2][2];
    logic [12:0] addr  [2][2];
    logic [7:0]  wdata [2][2];
    logic        ack   [2][2];
    logic [7:0]  rdata [2][2];
    logic        grant [2][2];
    logic [12:0] waddr [2];
    logic [12:0] raddr [2];
    logic [7:0]  din   [2];
    logic [7:0]  dout  [2];
    logic        wr    [2];

    logic [7:0]  mem0  [8192];
    logic [7:0]  mem1  [8192];
    bit          seen0 [8192];
    bit          seen1 [8192];

    exp_t        exp0_q [$];
    exp_t        exp1_q [$];
    logic [7:0]  model_rd [2][2];
    int          issue_cyc [2][2];
    int          wr_count [2];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          wr_base;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Blockram model: unwritten locations read back addr[7:0]^0x3C.
    always @(posedge clk) begin
        if (wr[0]) begin
            mem0[waddr[0]]  <= din[0];
            seen0[waddr[0]] <= 1'b1;
        end
        if (wr[1]) begin
            mem1[waddr[1]]  <= din[1];
            seen1[waddr[1]] <= 1'b1;
        end
        dout[0] <= seen0[raddr[0]] ? mem0[raddr[0]] : (raddr[0][7:0] ^ 8'h3C);
        dout[1] <= seen1[raddr[1]] ? mem1[raddr[1]] : (raddr[1][7:0] ^ 8'h3C);
    end

    ram_arbiter #(.ADDR_WIDTH(13), .FIXED_PRIO(0), .MAX_WAIT(8)) dut_rr (
        .clk(clk), .reset_n(rst_n[0]),
        .a_req(req[0][0]), .a_we(we[0][0]), .a_addr(addr[0][0]), .a_wdata(wdata[0][0]),
        .a_ack(ack[0][0]), .a_rdata(rdata[0][0]), .a_grant(grant[0][0]),
        .b_req(req[0][1]), .b_we(we[0][1]), .b_addr(addr[0][1]), .b_wdata(wdata[0][1]),
        .b_ack(ack[0][1]), .b_rdata(rdata[0][1]), .b_grant(grant[0][1]),
        .ram_waddr(waddr[0]), .ram_raddr(raddr[0]), .ram_din(din[0]),
        .ram_write(wr[0]), .ram_dout(dout[0])
    );

    ram_arbiter #(.ADDR_WIDTH(13), .FIXED_PRIO(1), .MAX_WAIT(4)) dut_fp (
        .clk(clk), .reset_n(rst_n[1]),
        .a_req(req[1][0]), .a_we(we[1][0]), .a_addr(addr[1][0]), .a_wdata(wdata[1][0]),
        .a_ack(ack[1][0]), .a_rdata(rdata[1][0]), .a_grant(grant[1][0]),
        .b_req(req[1][1]), .b_we(we[1][1]), .b_addr(addr[1][1]), .b_wdata(wdata[1][1]),
        .b_ack(ack[1][1]), .b_rdata(rdata[1][1]), .b_grant(grant[1][1]),
        .ram_waddr(waddr[1]), .ram_raddr(raddr[1]), .ram_din(din[1]),
        .ram_write(wr[1]), .ram_dout(dout[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input int d, input int p, input logic w, input logic [12:0] a,
                              input logic [7:0] v, input int lat);
        exp_t e;
        e.port = p; e.we = w; e.addr = a; e.data = v; e.lat = lat;
        if (d == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
    endtask

    task automatic check_zero(input int d);
        chk($sformatf("d%0d_rst_ctl", d),
            {27'd0, ack[d][0], ack[d][1], grant[d][0], grant[d][1], wr[d]}, 32'd0);
        chk($sformatf("d%0d_rst_rdata", d), {16'd0, rdata[d][0], rdata[d][1]}, 32'd0);
        chk($sformatf("d%0d_rst_addr", d), {6'd0, waddr[d], raddr[d]}, 32'd0);
        chk($sformatf("d%0d_rst_din", d), {24'd0, din[d]}, 32'd0);
    endtask

    task automatic mon(input int d);
        exp_t  e;
        string tag;
        if (grant[d][0] && grant[d][1]) begin
            checks++; failures++;
            $display("FAIL d%0d_grant_excl actual=both required=at_most_one", d);
        end
        if (ack[d][0] && ack[d][1]) begin
            checks++; failures++;
            $display("FAIL d%0d_ack_excl actual=both required=at_most_one", d);
        end
        if (wr[d]) wr_count[d]++;
        for (int p = 0; p < 2; p++) begin
            if (ack[d][p]) begin
                tag = $sformatf("d%0d%s", d, (p == 0) ? "A" : "B");
                if ((d == 0 && exp0_q.size() == 0) || (d == 1 && exp1_q.size() == 0)) begin
                    checks++; failures++;
                    $display("FAIL %s_unexpected_ack actual=ack required=no_ack", tag);
                end else begin
                    if (d == 0) e = exp0_q.pop_front();
                    else        e = exp1_q.pop_front();
                    chk({tag, "_order"}, p, e.port);
                    chk({tag, "_grant"}, {31'd0, grant[d][p]}, 32'd1);
                    chk({tag, "_other_grant"}, {31'd0, grant[d][1-p]}, 32'd0);
                    if (e.lat >= 0) chk({tag, "_latency"}, cyc - issue_cyc[d][p], e.lat);
                    if (e.we) begin
                        chk({tag, "_ram_write"}, {31'd0, wr[d]}, 32'd1);
                        chk({tag, "_waddr"}, {19'd0, waddr[d]}, {19'd0, e.addr});
                        chk({tag, "_din"}, {24'd0, din[d]}, {24'd0, e.data});
                    end else begin
                        chk({tag, "_rdata"}, {24'd0, rdata[d][p]}, {24'd0, e.data});
                        chk({tag, "_other_rdata"}, {24'd0, rdata[d][1-p]},
                            {24'd0, model_rd[d][1-p]});
                        model_rd[d][p] = e.data;
                    end
                end
            end
        end
    endtask

    task automatic issue(input int d, input int p, input logic w, input logic [12:0] a,
                         input logic [7:0] v, input bit hold);
        int n;
        req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdata[d][p] = v;
        issue_cyc[d][p] = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[d][p] && n < 60);
        if (!ack[d][p]) begin
            checks++; failures++;
            $display("FAIL d%0dp%0d_ack_timeout actual=no_ack required=ack", d, p);
        end
        @(posedge clk); #1;
        if (!hold) req[d][p] = 1'b0;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        #1 check_zero(d);
        @(negedge clk);
        rst_n[d] = 1'b1;
        model_rd[d][0] = 8'd0;
        model_rd[d][1] = 8'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1;
            wr_count[d] = 0;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = 13'd0; wdata[d][p] = 8'd0;
                model_rd[d][p] = 8'd0; issue_cyc[d][p] = 0;
            end
        end
        fork
            forever begin
                @(negedge clk);
                mon(0);
                mon(1);
            end
        join_none
        #1 rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #2 check_zero(0); check_zero(1);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // A write after reset, then B reads it back.
        expect_txn(0, 0, 1'b1, 13'h0100, 8'h5A, 1);
        issue(0, 0, 1'b1, 13'h0100, 8'h5A, 1'b0);
        expect_txn(0, 1, 1'b0, 13'h0100, 8'h5A, 3);
        issue(0, 1, 1'b0, 13'h0100, 8'h00, 1'b0);

        // Both ports request continuously from the first cycle after reset.
        do_reset(0);
        for (int i = 0; i < 6; i++) begin
            expect_txn(0, 0, 1'b1, 13'h0200 + 13'(i), 8'h10 + 8'(i), (i == 0) ? 1 : 5);
            expect_txn(0, 1, 1'b0, 13'h0200 + 13'(i), 8'h10 + 8'(i), 5);
        end
        fork
            for (int i = 0; i < 6; i++) issue(0, 0, 1'b1, 13'h0200 + 13'(i), 8'h10 + 8'(i), i < 5);
            for (int j = 0; j < 6; j++) issue(0, 1, 1'b0, 13'h0200 + 13'(j), 8'h00, j < 5);
        join

        // Reset lands in RWAIT of an A read: no ack, outputs cleared at once.
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 13'h0203;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n[0] = 1'b0;
        #1 check_zero(0);
        req[0][0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        model_rd[0][0] = 8'd0;
        model_rd[0][1] = 8'd0;
        @(posedge clk); #1;
        expect_txn(0, 0, 1'b0, 13'h0201, 8'h11, 3);
        issue(0, 0, 1'b0, 13'h0201, 8'h00, 1'b0);

        // Simultaneous requests with last grant A: round-robin picks B.
        @(posedge clk); #1;
        expect_txn(0, 1, 1'b1, 13'h0300, 8'h21, 1);
        expect_txn(0, 0, 1'b1, 13'h0301, 8'h22, 3);
        fork
            issue(0, 0, 1'b1, 13'h0301, 8'h22, 1'b0);
            issue(0, 1, 1'b1, 13'h0300, 8'h21, 1'b0);
        join

        // Stale req held one cycle past ack must not start a second write.
        @(posedge clk); #1;
        wr_base = wr_count[0];
        expect_txn(0, 0, 1'b1, 13'h0040, 8'h99, 1);
        issue(0, 0, 1'b1, 13'h0040, 8'h99, 1'b1);
        @(posedge clk); #1;
        req[0][0] = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("d0_single_write", wr_count[0] - wr_base, 32'd1);
        expect_txn(0, 1, 1'b0, 13'h0040, 8'h99, 3);
        issue(0, 1, 1'b0, 13'h0040, 8'h00, 1'b0);

        // Fixed priority: A reads back-to-back, B waits until counter reaches 4.
        expect_txn(1, 0, 1'b0, 13'h0010, 8'h2C, 3);
        expect_txn(1, 1, 1'b0, 13'h0020, 8'h1C, 7);
        expect_txn(1, 0, 1'b0, 13'h0011, 8'h2D, 7);
        expect_txn(1, 0, 1'b0, 13'h0012, 8'h2E, 4);
        fork
            begin
                issue(1, 0, 1'b0, 13'h0010, 8'h00, 1'b1);
                issue(1, 0, 1'b0, 13'h0011, 8'h00, 1'b1);
                issue(1, 0, 1'b0, 13'h0012, 8'h00, 1'b0);
            end
            issue(1, 1, 1'b0, 13'h0020, 8'h00, 1'b0);
        join

        // Fixed priority tie with last grant A: A still wins.
        @(posedge clk); #1;
        expect_txn(1, 0, 1'b1, 13'h0030, 8'h77, 1);
        expect_txn(1, 1, 1'b1, 13'h0031, 8'h88, 3);
        fork
            issue(1, 0, 1'b1, 13'h0030, 8'h77, 1'b0);
            issue(1, 1, 1'b1, 13'h0031, 8'h88, 1'b0);
        join

        repeat (5) @(posedge clk); #1;
        chk("d0_pending_expect", exp0_q.size(), 32'd0);
        chk("d1_pending_expect", exp1_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port-pair blockram (one sync write port, one sync read port, 1-cycle registered read) between two byte-wide requesters: port A (cpu) and port B (monitor).
- Lets the monitor load and dump memory while the cpu runs, replacing the static running-mux in front of the ram.
- Sequences each transaction through a small FSM.
- Arbitrates by round-robin, or by fixed A-priority with aging, so B is never starved.

Parameters:
- ADDR_WIDTH, 13, width of all byte addresses (8K bytes).
- FIXED_PRIO, 0, 0 = round-robin; 1 = A has priority, B protected by aging.
- MAX_WAIT, 8, cycles B may wait with req high before it is forced to win (FIXED_PRIO=1 only); range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_req / b_req  in  1  request; held high with we/addr/wdata stable until ack.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  ADDR_WIDTH  byte address.
- a_wdata / b_wdata  in  8  write data.
- a_ack / b_ack  out  1  one-cycle pulse: write done, or rdata valid.
- a_rdata / b_rdata  out  8  read data; registered; holds until that port's next read ack.
- a_grant / b_grant  out  1  high from the cycle after the decision through the ack cycle.
- ram_waddr / ram_raddr  out  ADDR_WIDTH  ram addresses.
- ram_din  out  8  ram write data.
- ram_write  out  1  ram write enable.
- ram_dout  in  8  ram read data, valid the cycle after ram_raddr is presented.

Behaviour:
- Reset (async, reset_n=0): state IDLE; every output 0; last_grant=B, so A wins the first simultaneous round; wait counter 0. A transaction in flight is abandoned with no ack and no further ram_write.
- States: IDLE, WRITE, RADDR, RWAIT, RACK.
- IDLE:
  - Evaluate the eligible requests. A port is ineligible in the single cycle after its own ack, which masks a stale req from registered requesters.
  - No eligible request: stay in IDLE.
  - On a win: latch winner, we, addr and wdata; set last_grant = winner.
  - Next state is WRITE if we=1, else RADDR.
- WRITE (1 cycle): ram_write=1 with ram_waddr/ram_din = latched values; winner ack=1 in the same cycle; next IDLE.
- RADDR: ram_raddr = latched addr; next RWAIT.
- RWAIT: capture ram_dout into the winner's rdata at the end of the cycle; next RACK.
- RACK: winner ack=1; rdata is already valid; next IDLE.
- Latency, counting the cycle req is first sampled in IDLE as cycle 0:
  - Write: ram_write and ack in cycle 1.
  - Read: ack in cycle 3.
  - Throughput: one write every 2 cycles, one read every 4 cycles.
- ram_write is high only in WRITE. ram_raddr holds its last value outside RADDR; reads have no side effects.
- Round-robin (FIXED_PRIO=0): with both eligible, grant the port ≠ last_grant. With one eligible, grant it.
- Fixed priority (FIXED_PRIO=1):
  - A wins ties.
  - The wait counter increments each cycle b_req=1 and B is not granted; it saturates at 255 and clears when B is granted or b_req=0.
  - When the counter ≥ MAX_WAIT, B wins the next IDLE decision regardless of a_req.
- Address/data: no arithmetic; values are passed through unchanged and are never wrapped or truncated.
- Same-address traffic: a write followed by a read gets new data, because transactions are strictly serialized. There is no read/write overlap, so no collision case exists.
- A requester dropping req mid-transaction: ignored; the transaction completes and ack is still pulsed.
- Grant exclusivity: a_grant and b_grant are never both high; a_ack and b_ack are never both high.

Test Plan:
- Reset, then A writes 0x5A to 0x0100 → ram_write=1, ram_waddr=0x0100, ram_din=0x5A and a_ack=1 one cycle after req; b_grant stays 0.
- B reads 0x0100 after the previous write → b_ack in cycle 3, b_rdata=0x5A; a_rdata unchanged.
- A and B both request from the first cycle after reset with FIXED_PRIO=0 → A served first, then B, then alternating A/B for 6 continuous requests each.
- FIXED_PRIO=1, MAX_WAIT=4, A requests continuously and B requests once → B granted at the first IDLE decision with counter ≥ 4; A resumes after b_ack.
- reset_n pulsed low during RWAIT of an A read → all outputs 0 immediately, no a_ack; the next request after reset completes normally.
- Requester keeps req high for one cycle after its ack → no duplicate transaction; exactly one ram_write per write request.
